pm_arbiter: RTL and testbench
=============================

# pm_arbiter

Arbiter and sequencer for the single read port of the program memory (PMem, synchronous read, 1-cycle latency). Shares the port between the instruction-fetch requester (one word per cycle) and a data requester that reads constant tables/boot images from program memory in bursts of 1–16 words. Gives fetch priority with a starvation bound for the data side, generates the fetch stall, and tags returned words to their owner. Sits between the fetch stage/program_memory address path and the PMem block.

## Interface
Parameters:
- AW, 16, address width
- DW, 32, word width
- MAX_WAIT, 4, cycles a pending data request may be refused before it wins over fetch (1..15)

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-low; 0 = in reset
- f_req  in  1  fetch requests a word this cycle
- f_addr  in  AW  fetch address
- f_gnt  out  1  fetch owns the port this cycle (combinational)
- f_valid  out  1  rdata holds fetch word (registered)
- stall_fetch  out  1  f_req && !f_gnt (combinational)
- d_req  in  1  data requester asks for a burst; held until d_gnt
- d_addr  in  AW  burst start address, sampled at d_gnt
- d_len  in  4  burst length minus one, sampled at d_gnt
- d_gnt  out  1  one-cycle pulse: burst accepted, first beat issued (combinational)
- d_valid  out  1  rdata holds a data beat (registered)
- d_last  out  1  with d_valid on final beat
- pm_addr  out  AW  address to PMem
- pm_dout  in  DW  PMem read data (valid one cycle after address)
- rdata  out  DW  returned word, = pm_dout

## Operation
- FSM states: IDLE, BURST.
- IDLE, per cycle, at most one grant:
  - d_req && wait_cnt >= MAX_WAIT: d_gnt=1, pm_addr=d_addr; load burst addr = d_addr+1, beats_left = d_len; go BURST if d_len != 0 else stay IDLE.
  - else f_req: f_gnt=1, pm_addr=f_addr.
  - else d_req: d_gnt as above.
  - else pm_addr=0, no grant.
- wait_cnt (4-bit): +1 each IDLE cycle with d_req && !d_gnt, saturating at 15; cleared on d_gnt.
- BURST: pm_addr = burst addr; addr +1 (wraps 0xFFFF→0x0000 modulo 2^AW); beats_left −1; f_gnt=0 so stall_fetch=f_req; leave to IDLE after beat with beats_left==0. d_req/d_addr/d_len ignored in BURST.
- Return tagging: owner of cycle N's issue registered; cycle N+1 asserts f_valid or d_valid; d_last registered from “final beat issued”.
- f_valid and d_valid never both 1; no grant → both 0 next cycle.

## Timing
- Grant and pm_addr same cycle as request (0-cycle arbitration); data one cycle later on rdata with valid.
- Burst of L=d_len+1 beats: d_gnt cycle T, beats issued T..T+L−1, d_valid T+1..T+L, d_last at T+L; fetch stalled T+1..T+L−1 (T too if data won).
- Back-to-back: new grant possible in cycle after BURST ends; fetch and data may alternate every cycle.
- Reset (asserted any time, incl. mid-burst): immediately IDLE, wait_cnt=0, burst addr=0, beats_left=0; f_valid=d_valid=d_last=0; f_gnt=d_gnt=0, stall_fetch=0, pm_addr=0 while reset=0. Aborted burst produces no further beats or d_last.
- First cycle after reset release: normal arbitration.

## Test plan
- Fetch only: f_req=1, f_addr 0x0000,0x0001,0x0002 -> f_gnt=1, pm_addr follows f_addr same cycle, f_valid=1 with matching rdata next cycle, stall_fetch=0, d_valid=0.
- Data only: d_req, d_addr=0x1230, d_len=3 -> d_gnt one pulse, pm_addr 0x1230..0x1233 over 4 cycles, d_valid 4 cycles, d_last on 4th only.
- Starvation: f_req held 1, d_req=1 (d_len=0) from cycle 0, MAX_WAIT=4 -> fetch granted cycles 0–3, d_gnt in cycle 4, stall_fetch=1 in cycle 4 only, wait_cnt back to 0.
- Wrap: d_addr=0xFFFE, d_len=2 -> pm_addr 0xFFFE,0xFFFF,0x0000; fetch stalled during burst then resumes with f_gnt next cycle.
- Reset mid-burst: d_len=15, assert reset=0 after 3rd beat -> all outputs 0 asynchronously, no d_last; after release, f_req granted first cycle.
- Idle: no requests -> pm_addr=0, no valids, stall_fetch=0.

Source files
------------

// File: rtl/pm_arbiter.sv
// Program-memory read-port arbiter: fetch has priority, data bursts win after MAX_WAIT refusals.
// Returned words are tagged to their owner one cycle after issue.
module pm_arbiter #(
    parameter int unsigned AW       = 16,
    parameter int unsigned DW       = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_gnt,
    output logic          f_valid,
    output logic          stall_fetch,
    input  logic          d_req,
    input  logic [AW-1:0] d_addr,
    input  logic [3:0]    d_len,
    output logic          d_gnt,
    output logic          d_valid,
    output logic          d_last,
    output logic [AW-1:0] pm_addr,
    input  logic [DW-1:0] pm_dout,
    output logic [DW-1:0] rdata
);

    typedef enum logic {StIdle, StBurst} state_t;

    state_t        r_state, w_state_d;
    logic [3:0]    r_wait_cnt, w_wait_d;
    logic [AW-1:0] r_baddr, w_baddr_d;
    logic [3:0]    r_beats, w_beats_d;
    logic          r_f_valid, r_d_valid, r_d_last;

    logic          w_f_gnt, w_d_gnt, w_d_win, w_d_issue, w_last;
    logic [AW-1:0] w_pm_addr;

    always_comb begin
        w_state_d = r_state;
        w_wait_d  = r_wait_cnt;
        w_baddr_d = r_baddr;
        w_beats_d = r_beats;
        w_f_gnt   = 1'b0;
        w_d_gnt   = 1'b0;
        w_d_win   = 1'b0;
        w_d_issue = 1'b0;
        w_last    = 1'b0;
        w_pm_addr = '0;
        // Everything combinational is forced quiet while reset is held.
        if (reset) begin
            unique case (r_state)
                StIdle: begin
                    w_d_win = d_req && ((r_wait_cnt >= 4'(MAX_WAIT)) || !f_req);
                    if (w_d_win) begin
                        w_d_gnt   = 1'b1;
                        w_d_issue = 1'b1;
                        w_pm_addr = d_addr;
                        w_baddr_d = d_addr + AW'(1);
                        w_beats_d = d_len;
                        w_wait_d  = 4'd0;
                        w_last    = (d_len == 4'd0);
                        if (d_len != 4'd0) begin
                            w_state_d = StBurst;
                        end
                    end else begin
                        if (f_req) begin
                            w_f_gnt   = 1'b1;
                            w_pm_addr = f_addr;
                        end
                        if (d_req && (r_wait_cnt != 4'hF)) begin
                            w_wait_d = r_wait_cnt + 4'd1;
                        end
                    end
                end
                StBurst: begin
                    w_d_issue = 1'b1;
                    w_pm_addr = r_baddr;
                    w_baddr_d = r_baddr + AW'(1);
                    w_beats_d = r_beats - 4'd1;
                    if (r_beats == 4'd1) begin
                        w_last    = 1'b1;
                        w_state_d = StIdle;
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= StIdle;
            r_wait_cnt <= 4'd0;
            r_baddr    <= '0;
            r_beats    <= 4'd0;
            r_f_valid  <= 1'b0;
            r_d_valid  <= 1'b0;
            r_d_last   <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_wait_cnt <= w_wait_d;
            r_baddr    <= w_baddr_d;
            r_beats    <= w_beats_d;
            r_f_valid  <= w_f_gnt;
            r_d_valid  <= w_d_issue;
            r_d_last   <= w_last;
        end
    end

    assign f_gnt       = w_f_gnt;
    assign d_gnt       = w_d_gnt;
    assign pm_addr     = w_pm_addr;
    assign stall_fetch = reset && f_req && !w_f_gnt;
    assign f_valid     = r_f_valid;
    assign d_valid     = r_d_valid;
    assign d_last      = r_d_last;
    assign rdata       = pm_dout;

endmodule

// File: tb/tb_pm_arbiter.sv
// Randomized scoreboard bench for pm_arbiter: a queue-based reference model predicts grants
// and pushes expected returns; a monitor pops and compares them one cycle later.
module tb_pm_arbiter;
    localparam int AW       = 16;
    localparam int DW       = 32;
    localparam int MAX_WAIT = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          f_req = 1'b0;
    logic [AW-1:0] f_addr = '0;
    logic          d_req = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [3:0]    d_len = '0;
    logic          f_gnt, f_valid, stall_fetch, d_gnt, d_valid, d_last;
    logic [AW-1:0] pm_addr;
    logic [DW-1:0] pm_dout = '0;
    logic [DW-1:0] rdata;

    pm_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk         (clk),
        .reset       (rst_n),
        .f_req       (f_req),
        .f_addr      (f_addr),
        .f_gnt       (f_gnt),
        .f_valid     (f_valid),
        .stall_fetch (stall_fetch),
        .d_req       (d_req),
        .d_addr      (d_addr),
        .d_len       (d_len),
        .d_gnt       (d_gnt),
        .d_valid     (d_valid),
        .d_last      (d_last),
        .pm_addr     (pm_addr),
        .pm_dout     (pm_dout),
        .rdata       (rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {a ^ 16'hA5C3, a};
    endfunction

    // Synchronous-read program memory with one-cycle latency.
    always @(posedge clk) pm_dout <= mem_word(pm_addr);

    typedef struct {
        int          owner;  // 0 none, 1 fetch, 2 data
        logic [15:0] addr;
        logic        last;
    } ret_t;

    ret_t        expq[$];
    logic [15:0] bq[$];
    int          waited = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    logic        granted = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model();
        ret_t        e;
        logic        ef, ed;
        logic [15:0] ea;
        e.owner = 0; e.addr = '0; e.last = 1'b0;
        ef = 1'b0; ed = 1'b0; ea = '0;
        if (!rst_n) begin
            bq.delete();
            waited = 0;
        end else if (bq.size() > 0) begin
            ea      = bq.pop_front();
            e.owner = 2;
            e.addr  = ea;
            e.last  = (bq.size() == 0);
        end else if (d_req && (waited >= MAX_WAIT || !f_req)) begin
            ed      = 1'b1;
            ea      = d_addr;
            e.owner = 2;
            e.addr  = d_addr;
            e.last  = (d_len == 4'd0);
            for (int k = 1; k <= int'(d_len); k++) bq.push_back(d_addr + 16'(k));
            waited  = 0;
        end else begin
            if (f_req) begin
                ef      = 1'b1;
                ea      = f_addr;
                e.owner = 1;
                e.addr  = f_addr;
            end
            if (d_req && waited < 15) waited++;
        end
        granted = ed;
        chk("f_gnt", 32'(f_gnt), 32'(ef));
        chk("d_gnt", 32'(d_gnt), 32'(ed));
        chk("stall_fetch", 32'(stall_fetch), 32'(rst_n && f_req && !ef));
        chk("pm_addr", 32'(pm_addr), 32'(ea));
        expq.push_back(e);
    endtask

    task automatic step(input logic rs, input logic fr, input logic [15:0] fa,
                        input logic dr, input logic [15:0] da, input logic [3:0] dl);
        @(posedge clk);
        #2;
        if (!rs && rst_n) expq.delete();
        rst_n  = rs;
        f_req  = fr;
        f_addr = fa;
        d_req  = dr;
        d_addr = da;
        d_len  = dl;
        #1;
        model();
    endtask

    // Monitor: registered outputs reflect the previous cycle's issue.
    initial begin
        ret_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("f_valid", 32'(f_valid), 32'(e.owner == 1));
                chk("d_valid", 32'(d_valid), 32'(e.owner == 2));
                chk("d_last", 32'(d_last), 32'(e.owner == 2 && e.last));
                if (e.owner != 0) chk("rdata", rdata, mem_word(e.addr));
            end
        end
    end

    initial begin
        int          gc;
        logic        dpend;
        logic [15:0] rda;
        logic [3:0]  rdl;
        logic        rs, fr;

        // Reset held, then fetch-only stream.
        step(1'b0, 1'b1, 16'h0007, 1'b1, 16'h0009, 4'd2);
        step(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 4'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 16'(i), 1'b0, 16'h0000, 4'd0);

        // Data-only burst of four beats.
        step(1'b1, 1'b0, 16'h0000, 1'b1, 16'h1230, 4'd3);
        chk("data_only_gnt", 32'(granted), 32'd1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 4'd0);

        // Starvation bound with fetch held.
        gc = -1;
        for (int c = 0; c < 20 && gc < 0; c++) begin
            step(1'b1, 1'b1, 16'h0100 + 16'(c), 1'b1, 16'h4000, 4'd0);
            if (granted) gc = c;
        end
        chk("starve_gnt_cycle", 32'(gc), 32'd4);
        step(1'b1, 1'b1, 16'h0200, 1'b0, 16'h0000, 4'd0);

        // Address wrap during a burst, fetch resumes afterwards.
        gc = -1;
        for (int c = 0; c < 20 && gc < 0; c++) begin
            step(1'b1, 1'b1, 16'h0300 + 16'(c), 1'b1, 16'hFFFE, 4'd2);
            if (granted) gc = c;
        end
        chk("wrap_gnt_cycle", 32'(gc), 32'd4);
        step(1'b1, 1'b1, 16'h0400, 1'b0, 16'h0000, 4'd0);
        step(1'b1, 1'b1, 16'h0400, 1'b0, 16'h0000, 4'd0);
        step(1'b1, 1'b1, 16'h0400, 1'b0, 16'h0000, 4'd0);
        chk("wrap_resume_fgnt", 32'(f_gnt), 32'd1);

        // Reset asserted mid-burst.
        step(1'b1, 1'b0, 16'h0000, 1'b1, 16'h2000, 4'd15);
        step(1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 4'd0);
        step(1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 4'd0);
        @(posedge clk);
        #4;
        rst_n = 1'b0;
        expq.delete();
        #1;
        chk("rst_f_valid", 32'(f_valid), 32'd0);
        chk("rst_d_valid", 32'(d_valid), 32'd0);
        chk("rst_d_last", 32'(d_last), 32'd0);
        chk("rst_pm_addr", 32'(pm_addr), 32'd0);
        chk("rst_stall", 32'(stall_fetch), 32'd0);
        chk("rst_f_gnt", 32'(f_gnt), 32'd0);
        step(1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 4'd0);
        step(1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 4'd0);
        step(1'b1, 1'b1, 16'h0055, 1'b0, 16'h0000, 4'd0);
        chk("post_rst_fgnt", 32'(f_gnt), 32'd1);

        // Idle.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h1234, 1'b0, 16'h5678, 4'd3);

        // Random traffic with occasional resets.
        dpend = 1'b0;
        rda = '0;
        rdl = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!dpend && $urandom_range(0, 4) == 0) begin
                dpend = 1'b1;
                rda   = 16'($urandom);
                rdl   = 4'($urandom);
            end
            fr = ($urandom_range(0, 9) < 7);
            rs = ($urandom_range(0, 199) != 0);
            step(rs, fr, 16'($urandom), dpend, rda, rdl);
            if (granted || !rs) dpend = 1'b0;
        end

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 4'd0);
        @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
